// File: rtl/adc_stream_pkg.sv
// Shared types, widths and helpers for the ADC sample stream.
// Used by adc_sample_fifo and adc_fifo_mem.
package adc_stream_pkg;

  localparam int ADC_NB_DEF    = 4;
  localparam int ADC_DEPTH_DEF = 8;

  typedef logic [ADC_NB_DEF-1:0] adc_code_t;

  localparam int ADC_PTR_W = $clog2(ADC_DEPTH_DEF);
  localparam int ADC_CNT_W = ADC_PTR_W + 1;

  // An accumulator holding 2^al codes of nb bits never overflows nb+al bits.
  function automatic int acc_width(input int nb, input int al);
    return nb + al;
  endfunction

endpackage

// File: rtl/adc_fifo_mem.sv
// DEPTH x NUM_BITS register array for the sample FIFO.
// One synchronous write port, one combinational read port, no reset.
module adc_fifo_mem
  import adc_stream_pkg::*;
#(
  parameter int NUM_BITS = ADC_NB_DEF,
  parameter int DEPTH    = ADC_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [NUM_BITS-1:0]      wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [NUM_BITS-1:0]      rdata
);

  logic [NUM_BITS-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/adc_sample_fifo.sv
// ADC capture front end: eoc edge detect, optional averaging, show-ahead FIFO.
// Define ADC_AVG_EN to average 2^AVG_LOG2 captures per output word.
module adc_sample_fifo
  import adc_stream_pkg::*;
#(
  parameter int NUM_BITS = ADC_NB_DEF,
  parameter int DEPTH    = ADC_DEPTH_DEF,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     eoc,
  input  logic [NUM_BITS-1:0]      d_in,
  output logic [NUM_BITS-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if (DEPTH < 2 || (1 << PW) != DEPTH || AVG_LOG2 < 1) begin : g_bad_cfg
    $error("adc_sample_fifo: bad DEPTH or AVG_LOG2");
  end

  logic                r_eoc_q;
  logic                w_cap;
  logic                w_push;
  logic [NUM_BITS-1:0] w_res;

  // eoc_q resets high so a level held across reset release is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_eoc_q <= 1'b1;
    else     r_eoc_q <= eoc;
  end

  assign w_cap = eoc & ~r_eoc_q;

`ifdef ADC_AVG_EN
  localparam int AW = acc_width(NUM_BITS, AVG_LOG2);

  logic [AW-1:0]       r_acc;
  logic [AVG_LOG2-1:0] r_smp_cnt;
  logic [AW-1:0]       w_sum;
  logic                w_last;

  assign w_sum  = r_acc + {{AVG_LOG2{1'b0}}, d_in};
  assign w_last = &r_smp_cnt;
  assign w_push = w_cap & w_last;
  assign w_res  = w_sum[AW-1:AVG_LOG2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc     <= '0;
      r_smp_cnt <= '0;
    end else if (w_cap) begin
      if (w_last) begin
        r_acc     <= '0;
        r_smp_cnt <= '0;
      end else begin
        r_acc     <= w_sum;
        r_smp_cnt <= r_smp_cnt + 1'b1;
      end
    end
  end
`else
  assign w_push = w_cap;
  assign w_res  = d_in;
`endif

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic          w_drop;

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign w_full    = (r_count == CW'(DEPTH));
  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  assign count    = r_count;
  assign overflow = r_ovf;

  adc_fifo_mem #(
    .NUM_BITS (NUM_BITS),
    .DEPTH    (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr),
    .waddr (r_wr_ptr),
    .wdata (w_res),
    .raddr (r_rd_ptr),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Randomized and directed bench for adc_sample_fifo against a queue model.
// Honours ADC_AVG_EN in the model the same way the design build does.
module tb_adc_sample_fifo;

  localparam int NB    = 4;
  localparam int DEPTH = 8;
  localparam int AL    = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          eoc;
  logic [NB-1:0] d_in;
  logic [NB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_ovf;

  adc_sample_fifo #(
    .NUM_BITS (NB),
    .DEPTH    (DEPTH),
    .AVG_LOG2 (AL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .eoc       (eoc),
    .d_in      (d_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int q[$];
  int grp[$];
  bit m_prev = 1'b1;
  bit m_ovf  = 1'b0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outs();
    chk("valid", int'(out_valid), int'(q.size() != 0));
    chk("count", int'(count), q.size());
    chk("ovf", int'(overflow), int'(m_ovf));
    if (q.size() != 0) chk("data", int'(out_data), q[0]);
  endtask

  task automatic model_edge(input bit e, input int d,
                            input bit rdy, input bit clr);
    bit cap;
    bit pop;
    bit push;
    int res;
    int sz;
    int s;
    cap    = e && !m_prev;
    m_prev = e;
    sz     = q.size();
    pop    = (sz > 0) && rdy;
    push   = 1'b0;
    res    = 0;
    if (cap) begin
`ifdef ADC_AVG_EN
      grp.push_back(d);
      if (grp.size() == (1 << AL)) begin
        s = 0;
        foreach (grp[i]) s += grp[i];
        res  = s / (1 << AL);
        push = 1'b1;
        grp.delete();
      end
`else
      s    = 0;
      res  = d;
      push = 1'b1;
`endif
    end
    if (pop) q.delete(0);
    if (push && (sz < DEPTH || pop)) q.push_back(res);
    if (push && sz == DEPTH && !pop) m_ovf = 1'b1;
    else if (clr)                   m_ovf = 1'b0;
  endtask

  task automatic cyc(input bit e, input int d, input bit rdy, input bit clr);
    eoc       = e;
    d_in      = d[NB-1:0];
    out_ready = rdy;
    clr_ovf   = clr;
    @(posedge clk);
    model_edge(e, d, rdy, clr);
    @(negedge clk);
    chk_outs();
  endtask

  task automatic pulse(input int d, input bit rdy);
    cyc(1'b1, d, rdy, 1'b0);
    cyc(1'b0, d, rdy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 0, 1'b1, 1'b0);
    chk("drained", int'(out_valid), 0);
  endtask

  task automatic model_reset();
    q.delete();
    grp.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b1;
  endtask

  task automatic do_reset(input bit e);
    eoc       = e;
    d_in      = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    #2 rst    = 1'b1;
    model_reset();
    #1 chk_outs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_outs();
  endtask

  int codes1[4] = '{15, 14, 1, 2};
  int codes2[4] = '{1, 1, 1, 2};

  initial begin
    rst       = 1'b1;
    eoc       = 1'b1;
    d_in      = '0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    @(negedge clk);
    do_reset(1'b1);

    // eoc held across reset release must not capture
    cyc(1'b1, 5, 1'b0, 1'b0);
    cyc(1'b1, 5, 1'b0, 1'b0);
    chk("no_cap_count", int'(count), 0);
    cyc(1'b0, 10, 1'b0, 1'b0);
    cyc(1'b1, 10, 1'b0, 1'b0);
`ifndef ADC_AVG_EN
    chk("first_word", int'(out_data), 10);
`endif
    cyc(1'b0, 10, 1'b0, 1'b0);
    drain();

    for (int i = 0; i < 5; i++) cyc(1'b1, 3, 1'b0, 1'b0);
    cyc(1'b0, 3, 1'b0, 1'b0);
    drain();

    for (int i = 1; i <= 9; i++) pulse(i, 1'b0);
    drain();
    cyc(1'b0, 0, 1'b0, 1'b1);

    for (int i = 1; i <= 4 * DEPTH + 4; i++) pulse(i & 15, 1'b0);
    cyc(1'b1, 12, 1'b1, 1'b0);
    cyc(1'b0, 12, 1'b0, 1'b1);
    drain();
    cyc(1'b0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) pulse(codes1[i], 1'b0);
`ifdef ADC_AVG_EN
    chk("avg_32", int'(out_data), 8);
`endif
    for (int i = 0; i < 4; i++) pulse(codes2[i], 1'b0);
    drain();

    pulse(7, 1'b0);
    pulse(9, 1'b0);
    do_reset(1'b0);
    chk("rst_empty", int'(out_valid), 0);
    for (int i = 0; i < 4; i++) pulse(4 + i, 1'b0);
    drain();

    begin
      bit e;
      int d;
      e = 1'b0;
      d = 0;
      for (int i = 0; i < 3000; i++) begin
        if (!e) d = int'($urandom_range(0, 15));
        e = ($urandom_range(0, 2) != 0) ? ~e : e;
        cyc(e, d, $urandom_range(0, 3) == 0,
            $urandom_range(0, 15) == 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
